// File: rtl/player_motion_controller_pkg.sv
// Shared types and constants for the player motion controller and its step logic.
package player_motion_controller_pkg;

    localparam int unsigned Y_W  = 4;
    localparam int unsigned WD_W = 5;

    localparam logic [Y_W-1:0]  Y_MIN    = 4'd1;
    localparam logic [Y_W-1:0]  Y_MAX    = 4'd14;
    localparam logic [WD_W-1:0] WD_LIMIT = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_BUSY,
        WAIT_DONE,
        APPLY
    } state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } coll_flags_t;

    // Keep rows inside the band where the detector's +-1 neighbour reads stay valid.
    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        logic [Y_W-1:0] r;
        r = y;
        if (y < Y_MIN) r = Y_MIN;
        else if (y > Y_MAX) r = Y_MAX;
        return r;
    endfunction

endpackage

// File: rtl/player_motion_controller_motion_step.sv
// Combinational next-position logic; vertical behaviour selected by GRAVITY_EN.
module motion_step
    import player_motion_controller_pkg::*;
#(
    parameter int unsigned TILEMAP_LENGTH = 100,
    parameter int unsigned X_W            = 7
`ifdef GRAVITY_EN
    ,
    parameter int unsigned JUMP_HEIGHT    = 3,
    parameter int unsigned JC_W           = 2
`endif
) (
    input  logic [X_W-1:0]  x,
    input  logic [Y_W-1:0]  y,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_jump,
`ifdef GRAVITY_EN
    input  logic            jumping,
    input  logic [JC_W-1:0] jump_cnt,
    output logic            next_jumping,
    output logic [JC_W-1:0] next_jump_cnt,
`else
    input  logic            btn_down,
`endif
    input  coll_flags_t     coll,
    output logic [X_W-1:0]  next_x,
    output logic [Y_W-1:0]  next_y
);

    localparam logic [X_W-1:0] X_LO = X_W'(1);
    localparam logic [X_W-1:0] X_HI = X_W'(TILEMAP_LENGTH - 2);

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    // Horizontal: a single pressed direction moves one tile unless blocked or at the edge.
    always_comb begin
        nx = x;
        if (btn_left && !btn_right && !coll.left && (x > X_LO))
            nx = x - X_W'(1);
        else if (btn_right && !btn_left && !coll.right && (x < X_HI))
            nx = x + X_W'(1);
        next_x = (nx < X_LO) ? X_LO : ((nx > X_HI) ? X_HI : nx);
    end

`ifdef GRAVITY_EN
    logic            jump_start;
    logic            ascending;
    logic [JC_W-1:0] cnt;

    // A jump takes its first row on the same update it starts.
    always_comb begin
        ny            = y;
        next_jumping  = jumping;
        next_jump_cnt = jump_cnt;
        jump_start    = btn_jump && coll.down && !jumping;
        ascending     = jumping || jump_start;
        cnt           = jump_start ? JC_W'(JUMP_HEIGHT) : jump_cnt;
        if (ascending) begin
            if (coll.up || (cnt == '0) || (y <= Y_MIN)) begin
                next_jumping  = 1'b0;
                next_jump_cnt = '0;
            end else begin
                ny            = y - Y_W'(1);
                next_jump_cnt = cnt - JC_W'(1);
                next_jumping  = (cnt != JC_W'(1));
            end
        end else if (!coll.down && (y < Y_MAX)) begin
            ny = y + Y_W'(1);
        end
        next_y = clamp_y(ny);
    end
`else
    always_comb begin
        ny = y;
        if (btn_jump && !btn_down && !coll.up && (y > Y_MIN))
            ny = y - Y_W'(1);
        else if (btn_down && !btn_jump && !coll.down && (y < Y_MAX))
            ny = y + Y_W'(1);
        next_y = clamp_y(ny);
    end
`endif

endmodule

// File: rtl/player_motion_controller.sv
// Frame-update sequencer: handshakes with the collision detector, then applies one move.
// Optional GRAVITY_EN selects jump/fall physics instead of free up/down movement.
module player_motion_controller
    import player_motion_controller_pkg::*;
#(
    parameter int unsigned TILEMAP_LENGTH = 100,
    parameter int unsigned X_W            = 7,
    parameter int unsigned JUMP_HEIGHT    = 3,
    parameter int unsigned X_START        = 1,
    parameter int unsigned Y_START        = 13
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           tick,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_jump,
    input  logic           btn_down,
    input  logic           coll_left,
    input  logic           coll_right,
    input  logic           coll_up,
    input  logic           coll_down,
    input  logic           coll_done,
    output logic           coll_enable,
    output logic [X_W-1:0] x_location,
    output logic [Y_W-1:0] y_location,
    output logic           jumping,
    output logic           update_done,
    output logic           timeout
);

    state_t          state, next_state;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            latch_en;
    logic            timeout_evt;
    coll_flags_t     coll_q;
    logic [X_W-1:0]  next_x;
    logic [Y_W-1:0]  next_y;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Detector idles with coll_done high, so a request is seen as a low phase then a high edge.
    always_comb begin
        next_state  = state;
        wd_d        = '0;
        latch_en    = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE:      if (tick) next_state = REQ;
            REQ:       next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (wd_q == WD_LIMIT) begin
                    timeout_evt = 1'b1;
                    next_state  = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (!coll_done) next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wd_q == WD_LIMIT) begin
                    timeout_evt = 1'b1;
                    next_state  = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (coll_done) begin
                        latch_en   = 1'b1;
                        next_state = APPLY;
                    end
                end
            end
            APPLY:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_location  <= X_W'(X_START);
            y_location  <= Y_W'(Y_START);
            wd_q        <= '0;
            coll_q      <= '0;
            coll_enable <= 1'b0;
            update_done <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            coll_enable <= (next_state == REQ);
            update_done <= (state == APPLY) || timeout_evt;
            if (timeout_evt) timeout <= 1'b1;
            if (latch_en) begin
                coll_q <= '{left: coll_left, right: coll_right, up: coll_up, down: coll_down};
            end
            if (state == APPLY) begin
                x_location <= next_x;
                y_location <= next_y;
            end
        end
    end

`ifdef GRAVITY_EN
    localparam int unsigned JC_W = $clog2(JUMP_HEIGHT + 1);

    logic [JC_W-1:0] jump_cnt, next_jump_cnt;
    logic            next_jumping;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            jumping  <= 1'b0;
            jump_cnt <= '0;
        end else if (state == APPLY) begin
            jumping  <= next_jumping;
            jump_cnt <= next_jump_cnt;
        end
    end

    motion_step #(
        .TILEMAP_LENGTH (TILEMAP_LENGTH),
        .X_W            (X_W),
        .JUMP_HEIGHT    (JUMP_HEIGHT),
        .JC_W           (JC_W)
    ) u_motion_step (
        .x             (x_location),
        .y             (y_location),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_jump      (btn_jump),
        .jumping       (jumping),
        .jump_cnt      (jump_cnt),
        .next_jumping  (next_jumping),
        .next_jump_cnt (next_jump_cnt),
        .coll          (coll_q),
        .next_x        (next_x),
        .next_y        (next_y)
    );
`else
    assign jumping = 1'b0;

    motion_step #(
        .TILEMAP_LENGTH (TILEMAP_LENGTH),
        .X_W            (X_W)
    ) u_motion_step (
        .x         (x_location),
        .y         (y_location),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .btn_down  (btn_down),
        .coll      (coll_q),
        .next_x    (next_x),
        .next_y    (next_y)
    );
`endif

endmodule
